// File: rtl/dsack_gen_if.sv
// 68030 bus-termination signal bundle between CPU-side decode (master) and dsack_gen (slave).
// BERR status signals exist only when DSACK_GEN_BERR_STATUS_EN is defined.
interface dsack_gen_if #(
    parameter int NREG = 4
);
    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic            nAS;
    logic            nDS;
    logic            RnW;
    logic [NREG-1:0] nSEL;
    logic [1:0]      DSACK;
    logic            BERR;
    logic            BUSY;
`ifdef DSACK_GEN_BERR_STATUS_EN
    logic            BERR_CLR;
    logic            BERR_SEEN;
    logic [IDX_W:0]  BERR_REG;

    modport master (output nAS, nDS, RnW, nSEL, BERR_CLR,
                    input  DSACK, BERR, BUSY, BERR_SEEN, BERR_REG);
    modport slave  (input  nAS, nDS, RnW, nSEL, BERR_CLR,
                    output DSACK, BERR, BUSY, BERR_SEEN, BERR_REG);
`else
    modport master (output nAS, nDS, RnW, nSEL,
                    input  DSACK, BERR, BUSY);
    modport slave  (input  nAS, nDS, RnW, nSEL,
                    output DSACK, BERR, BUSY);
`endif
endinterface

// File: rtl/dsack_gen.sv
// 68030 DSACK/BERR termination with per-region waits and port width; DSACK_GEN_BERR_STATUS_EN adds sticky BERR status.
// Latency: DSACK registered N+1 edges after nAS first sampled low with a select (N = region waits).
// Backpressure: writes hold off termination while nDS is high; DSACK holds until nAS is sampled high.
module dsack_gen #(
    parameter int                       NREG      = 4,
    parameter int                       WAIT_W    = 4,
    parameter logic [NREG*WAIT_W-1:0]   REG_WAITS = {(NREG*WAIT_W){1'b0}},
    parameter logic [NREG*2-1:0]        REG_PORT  = {NREG{2'b11}},
    parameter int                       TO_W      = 6
) (
    input  logic        CPU_CLK,
    input  logic        nRST,
    dsack_gen_if.slave  bus
);
    localparam int              IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [TO_W-1:0] TMAX  = {TO_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WAIT_W-1:0] wcnt_q;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [1:0]        dsack_q;
    logic              berr_q, berr_d;
    logic              busy_q;
    logic              sel_valid;
    logic [IDX_W-1:0]  pick;
    logic              gate, enter_ack, ack_next;

    function automatic logic [WAIT_W-1:0] wait_of(input logic [IDX_W-1:0] idx);
        return REG_WAITS[int'(idx)*WAIT_W +: WAIT_W];
    endfunction

    function automatic logic [1:0] port_of(input logic [IDX_W-1:0] idx);
        logic [1:0] p;
        p = REG_PORT[int'(idx)*2 +: 2];
        return (p == 2'b00) ? 2'b11 : p;
    endfunction

    // Descending scan so the lowest-index active select wins.
    always_comb begin
        sel_valid = 1'b0;
        pick      = '0;
        for (int i = NREG-1; i >= 0; i--) begin
            if (!bus.nSEL[i]) begin
                sel_valid = 1'b1;
                pick      = IDX_W'(i);
            end
        end
    end

    assign gate = bus.RnW | ~bus.nDS;

    always_comb begin
        enter_ack = 1'b0;
        if (!bus.nAS && gate) begin
            case (state_q)
                S_IDLE:  enter_ack = sel_valid && (wait_of(pick) == '0);
                S_WAIT:  enter_ack = (wcnt_q <= WAIT_W'(1));
                default: enter_ack = 1'b0;
            endcase
        end
    end

    assign ack_next = enter_ack | ((state_q == S_ACK) & ~bus.nAS);

    // Watchdog freezes on the edge termination is taken, so ACK beats a same-edge timeout.
    always_comb begin
        if (bus.nAS)                          tcnt_d = '0;
        else if (ack_next || tcnt_q == TMAX)  tcnt_d = tcnt_q;
        else                                  tcnt_d = tcnt_q + 1'b1;
    end

    assign berr_d = ~bus.nAS & (tcnt_d == TMAX);

    always_ff @(posedge CPU_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            dsack_q <= 2'b00;
            berr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            berr_q <= berr_d;
            case (state_q)
                S_IDLE: begin
                    if (!bus.nAS && sel_valid) begin
                        idx_q  <= pick;
                        wcnt_q <= wait_of(pick);
                    end
                    if (enter_ack) begin
                        state_q <= S_ACK;
                        dsack_q <= port_of(pick);
                        busy_q  <= 1'b1;
                    end else if (!bus.nAS && sel_valid && wait_of(pick) != '0) begin
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.nAS) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (enter_ack) begin
                        state_q <= S_ACK;
                        dsack_q <= port_of(idx_q);
                    end else if (wcnt_q > WAIT_W'(1)) begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                S_ACK: begin
                    if (bus.nAS) begin
                        state_q <= S_IDLE;
                        dsack_q <= 2'b00;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    dsack_q <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DSACK = dsack_q;
    assign bus.BERR  = berr_q;
    assign bus.BUSY  = busy_q;

`ifdef DSACK_GEN_BERR_STATUS_EN
    logic             berr_seen_q;
    logic [IDX_W:0]   berr_reg_q;
    logic [IDX_W:0]   berr_cap;

    // Mid-cycle the latched region is reported; in IDLE the live decode is.
    assign berr_cap = busy_q ? {1'b1, idx_q} : {sel_valid, pick};

    always_ff @(posedge CPU_CLK or negedge nRST) begin
        if (!nRST) begin
            berr_seen_q <= 1'b0;
            berr_reg_q  <= '0;
        end else if (berr_d && !berr_q) begin
            berr_seen_q <= 1'b1;
            berr_reg_q  <= berr_cap;
        end else if (bus.BERR_CLR) begin
            berr_seen_q <= 1'b0;
            berr_reg_q  <= '0;
        end
    end

    assign bus.BERR_SEEN = berr_seen_q;
    assign bus.BERR_REG  = berr_reg_q;
`endif
endmodule
